dmem_port_arbiter: RTL and testbench

Sequencer and arbiter that shares the single data_memory port (address, write data, read/write enables, size, and memory-mapped serial IO behind it) between two requesters: the processor core and the debug/loader port. Only one access is in flight at a time. Each access is taken through a fixed grant → access → response sequence with a configurable read latency. The block sits between the core's MEM stage and data_memory; the core stalls on `busy_out` while its request is pending.

---
 rtl/dmem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single data_memory port between the processor core and the
//   debug/loader requester. One access is in flight at a time, sequenced as
//   IDLE (arbitrate + latch) -> ACCESS (drive memory) -> RESP (ack pulse).
//
// Parameters
//   RD_LAT : cycles m_re is held before read data is captured (1..15)
//   AW     : address width
//
// Ports
//   clock, reset         : rising-edge clock, synchronous active-low reset
//   c_req/c_we/c_addr/c_wdata/c_size : core request (held until c_ack)
//   c_ack, c_rdata       : core completion pulse and read data
//   d_req/d_we/d_addr/d_wdata/d_size : debug request (held until d_ack)
//   d_ack, d_rdata       : debug completion pulse and read data
//   m_addr/m_wdata/m_size/m_re/m_we  : data_memory request side
//   m_rdata              : data_memory read data
//   busy_out             : core stall (c_req && !c_ack), combinational
//   owner_out            : owner of current/most recent grant (0 core, 1 debug)
//
// Build option
//   DMEM_ARB_FIXED_PRIO_EN : when defined the core always wins ties
//                            (debug may starve); otherwise round-robin.
module dmem_port_arbiter #(
  parameter int RD_LAT = 1,
  parameter int AW     = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [31:0]   c_wdata,
  input  logic [1:0]    c_size,
  output logic          c_ack,
  output logic [31:0]   c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [1:0]    d_size,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  output logic [1:0]    m_size,
  output logic          m_re,
  output logic          m_we,
  input  logic [31:0]   m_rdata,
  output logic          busy_out,
  output logic          owner_out
);

  localparam logic [3:0] LAT = 4'(RD_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            owner_q, owner_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [31:0]     m_wdata_q, m_wdata_d;
  logic [1:0]      m_size_q, m_size_d;
  logic            m_re_q, m_re_d;
  logic            m_we_q, m_we_d;
  logic            c_ack_q, c_ack_d;
  logic            d_ack_q, d_ack_d;
  logic [31:0]     c_rdata_q, c_rdata_d;
  logic [31:0]     d_rdata_q, d_rdata_d;
  logic            grant_dbg;
  logic            sel_we;

  // Winner when at least one request is present: 1 selects debug.
  always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
    grant_dbg = ~c_req;
`else
    if (c_req && d_req) grant_dbg = ~owner_q;
    else                grant_dbg = ~c_req;
`endif
  end

  assign sel_we = grant_dbg ? d_we : c_we;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_size_d  = m_size_q;
    m_re_d    = 1'b0;
    m_we_d    = 1'b0;
    c_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    c_rdata_d = '0;
    d_rdata_d = '0;
    case (state_q)
      S_IDLE: begin
        if (c_req || d_req) begin
          owner_d   = grant_dbg;
          m_addr_d  = grant_dbg ? d_addr  : c_addr;
          m_wdata_d = grant_dbg ? d_wdata : c_wdata;
          m_size_d  = grant_dbg ? d_size  : c_size;
          m_re_d    = ~sel_we;
          m_we_d    = sel_we;
          cnt_d     = sel_we ? 4'd1 : LAT;
          state_d   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q <= 4'd1) begin
          // Last ACCESS edge: capture read data straight into the owner's
          // response register so it appears together with the ack.
          cnt_d   = '0;
          state_d = S_RESP;
          if (owner_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = m_we_q ? '0 : m_rdata;
          end else begin
            c_ack_d   = 1'b1;
            c_rdata_d = m_we_q ? '0 : m_rdata;
          end
        end else begin
          cnt_d  = cnt_q - 4'd1;
          m_re_d = m_re_q;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b1;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_size_q  <= '0;
      m_re_q    <= 1'b0;
      m_we_q    <= 1'b0;
      c_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_size_q  <= m_size_d;
      m_re_q    <= m_re_d;
      m_we_q    <= m_we_d;
      c_ack_q   <= c_ack_d;
      d_ack_q   <= d_ack_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign c_ack     = c_ack_q;
  assign d_ack     = d_ack_q;
  assign c_rdata   = c_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_size    = m_size_q;
  assign m_re      = m_re_q;
  assign m_we      = m_we_q;
  assign owner_out = owner_q;
  assign busy_out  = c_req & ~c_ack_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for dmem_port_arbiter with RD_LAT=3.
module tb_dmem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata, m_rdata;
  logic [1:0]  c_size, d_size;
  logic        c_ack, d_ack, m_re, m_we, busy_out, owner_out;
  logic [31:0] c_rdata, d_rdata, m_addr, m_wdata;
  logic [1:0]  m_size;

  int unsigned total = 0;
  int unsigned passed = 0;

  dmem_port_arbiter #(.RD_LAT(3), .AW(32)) dut (
    .clock(clock), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_size(c_size),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size), .m_re(m_re), .m_we(m_we),
    .m_rdata(m_rdata), .busy_out(busy_out), .owner_out(owner_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected grant order for four back-to-back ties (1 = debug).
  logic [3:0] exp_order;
  logic       got_d;
  int unsigned waited;
  logic       got;

  initial begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_order = 4'b0000;
`else
    exp_order = 4'b1010;
`endif
    reset = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = '0; c_wdata = '0; c_size = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_size = '0;
    m_rdata = 32'hDEADBEEF;
    tick(); tick();
    // Reset state
    check("rst_c_ack", c_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_c_rdata", c_rdata, 0);
    check("rst_m_re_we", {m_re, m_we}, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata_size", {m_wdata, m_size}, 0);
    check("rst_owner", owner_out, 1);
    check("rst_busy", busy_out, 1);
    c_req = 1'b0;
    reset = 1'b1;
    tick();

    // Core read, RD_LAT=3, with address change mid-ACCESS
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_size = 2'd2;
    tick();
    check("rd_m_re_1", m_re, 1);
    check("rd_m_addr_1", m_addr, 32'h10);
    check("rd_m_size", m_size, 2);
    check("rd_owner", owner_out, 0);
    check("rd_busy_1", busy_out, 1);
    c_addr = 32'h20;
    tick();
    check("rd_m_re_2", m_re, 1);
    check("rd_m_addr_2", m_addr, 32'h10);
    check("rd_ack_early", c_ack, 0);
    tick();
    check("rd_m_re_3", m_re, 1);
    check("rd_m_addr_3", m_addr, 32'h10);
    tick();
    check("rd_m_re_off", m_re, 0);
    check("rd_c_ack", c_ack, 1);
    check("rd_c_rdata", c_rdata, 32'hDEADBEEF);
    check("rd_d_ack", d_ack, 0);
    check("rd_busy_ack", busy_out, 0);
    c_req = 1'b0;
    tick();
    check("rd_c_ack_off", c_ack, 0);

    // Debug write
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000_0004; d_wdata = 32'h55; d_size = 2'd1;
    tick();
    check("wr_m_we", m_we, 1);
    check("wr_m_re", m_re, 0);
    check("wr_m_addr", m_addr, 32'h1000_0004);
    check("wr_m_wdata", m_wdata, 32'h55);
    check("wr_owner", owner_out, 1);
    check("wr_busy", busy_out, 0);
    tick();
    check("wr_m_we_off", m_we, 0);
    check("wr_d_ack", d_ack, 1);
    check("wr_d_rdata", d_rdata, 0);
    check("wr_c_ack", c_ack, 0);
    d_req = 1'b0;
    tick();
    check("wr_d_ack_off", d_ack, 0);

    // Both requesters held continuously for four transactions
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    got_d = 1'b0;
    for (int t = 0; t < 4; t++) begin
      got = 1'b0;
      waited = 0;
      while (!got && waited < 12) begin
        tick();
        waited++;
        if (c_ack || d_ack) got = 1'b1;
        if (d_ack) got_d = 1'b1;
      end
      check("rr_ack_seen", got, 1);
      check("rr_one_ack", c_ack & d_ack, 0);
      check("rr_winner", d_ack, exp_order[t]);
      check("rr_latency", waited, (t == 0) ? 4 : 5);
      if (t == 3) begin
        c_req = 1'b0;
        d_req = 1'b0;
      end
    end
`ifdef DMEM_ARB_FIXED_PRIO_EN
    check("fp_no_d_ack", got_d, 0);
`else
    check("rr_d_served", got_d, 1);
`endif
    tick(); tick();
    check("rr_idle", {m_re, m_we, c_ack, d_ack}, 0);

    // Reset during the 2nd ACCESS cycle of a core read
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h30;
    tick();
    tick();
    check("mr_m_re", m_re, 1);
    reset = 1'b0;
    tick();
    check("mr_m_re_off", m_re, 0);
    check("mr_m_addr", m_addr, 0);
    check("mr_owner", owner_out, 1);
    check("mr_acks", {c_ack, d_ack}, 0);
    check("mr_busy", busy_out, 1);
    reset = 1'b1;
    c_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (c_ack || d_ack || m_re) got = 1'b1;
    end
    check("mr_no_ack", got, 0);

    // First tie after reset goes to the core, loser follows after one IDLE
    c_req = 1'b1; c_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h88; d_wdata = 32'hA5;
    tick();
    check("tie_owner", owner_out, 0);
    check("tie_m_addr", m_addr, 32'h44);
    tick(); tick(); tick();
    check("tie_c_ack", c_ack, 1);
    c_req = 1'b0;
    tick();
    check("tie_idle", {m_re, m_we}, 0);
    tick();
    check("tie_loser_owner", owner_out, 1);
    check("tie_loser_we", m_we, 1);
    check("tie_loser_addr", m_addr, 32'h88);
    tick();
    check("tie_d_ack", d_ack, 1);
    d_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
